// File: rtl/jtag_tap_regs.sv
// Instruction, BYPASS, IDCODE and USER registers behind a JTAG TAP controller,
// plus the TDO mux. Register actions key off the TAP state presented at each TCK edge.
module jtag_tap_regs #(
   parameter int                     IR_WIDTH      = 4,
   parameter logic [IR_WIDTH-1:0]    IDCODE_OPCODE = IR_WIDTH'(4'h1),
   parameter logic [IR_WIDTH-1:0]    USER_OPCODE   = IR_WIDTH'(4'h8),
   parameter logic [31:0]            IDCODE_VALUE  = 32'h1000_0001,
   parameter int                     USER_WIDTH    = 8
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [3:0]            state,
   input  logic                  tdi,
   output logic                  tdo,
   output logic                  tdo_en,
   output logic [IR_WIDTH-1:0]   ir,
   input  logic [USER_WIDTH-1:0] user_capture,
   output logic [USER_WIDTH-1:0] user_update,
   output logic                  user_strobe
);

   typedef enum logic [3:0] {
      TLR      = 4'd15,
      RTI      = 4'd12,
      SEL_DR   = 4'd7,
      CAP_DR   = 4'd6,
      SH_DR    = 4'd2,
      EX1_DR   = 4'd1,
      PAUSE_DR = 4'd3,
      EX2_DR   = 4'd0,
      UPD_DR   = 4'd5,
      SEL_IR   = 4'd4,
      CAP_IR   = 4'd14,
      SH_IR    = 4'd10,
      EX1_IR   = 4'd9,
      PAUSE_IR = 4'd11,
      EX2_IR   = 4'd8,
      UPD_IR   = 4'd13
   } tap_state_t;

   tap_state_t            tap;
   logic [IR_WIDTH-1:0]   ir_shift;
   logic [31:0]           idcode_shift;
   logic [USER_WIDTH-1:0] user_shift;
   logic                  bypass;
   logic                  sel_idcode;
   logic                  sel_user;
   logic [IR_WIDTH:0]     ir_cat;
   logic [32:0]           idcode_cat;
   logic [USER_WIDTH:0]   user_cat;

   assign tap        = tap_state_t'(state);
   assign sel_idcode = (ir == IDCODE_OPCODE);
   assign sel_user   = (ir == USER_OPCODE);

   // Concatenating tdi above each register makes a right shift a simple slice,
   // which also works for a one-bit USER register.
   assign ir_cat     = {tdi, ir_shift};
   assign idcode_cat = {tdi, idcode_shift};
   assign user_cat   = {tdi, user_shift};

   assign tdo_en = (tap == SH_DR) || (tap == SH_IR);

   // All register actions; user_strobe drops on every edge unless re-armed by Update-DR.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         ir           <= IDCODE_OPCODE;
         ir_shift     <= '0;
         idcode_shift <= '0;
         user_shift   <= '0;
         bypass       <= 1'b0;
         user_update  <= '0;
         user_strobe  <= 1'b0;
      end else begin
         user_strobe <= 1'b0;
         case (tap)
            TLR:    ir       <= IDCODE_OPCODE;
            CAP_IR: ir_shift <= IR_WIDTH'(1);
            SH_IR:  ir_shift <= ir_cat[IR_WIDTH:1];
            UPD_IR: ir       <= ir_shift;
            CAP_DR: begin
               if (sel_idcode)    idcode_shift <= IDCODE_VALUE;
               else if (sel_user) user_shift   <= user_capture;
               else               bypass       <= 1'b0;
            end
            SH_DR: begin
               if (sel_idcode)    idcode_shift <= idcode_cat[32:1];
               else if (sel_user) user_shift   <= user_cat[USER_WIDTH:1];
               else               bypass       <= tdi;
            end
            UPD_DR: begin
               if (sel_user) begin
                  user_update <= user_shift;
                  user_strobe <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // TDO presents bit 0 of whichever register is shifting, otherwise idles low.
   always_comb begin
      tdo = 1'b0;
      case (tap)
         SH_IR: tdo = ir_shift[0];
         SH_DR: begin
            if (sel_idcode)    tdo = idcode_shift[0];
            else if (sel_user) tdo = user_shift[0];
            else               tdo = bypass;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/jtag_tap_regs.md
Name: jtag_tap_regs

Overview:
Data-path stage directly downstream of the JTAG TAP controller FSM. Consumes the TAP state code and TDI, and implements the following registers:
- Instruction register (IR).
- BYPASS, IDCODE and one USER data register.
- The TDO output mux.

Single clock domain on CLK (TCK); all register actions happen on the rising CLK edge, keyed on the current TAP state presented at that edge.

Parameters:
- IR_WIDTH, 4, instruction register width; must be >= 2.
- IDCODE_OPCODE, 4'h1, opcode selecting IDCODE; must not be all-ones.
- USER_OPCODE, 4'h8, opcode selecting USER DR; must differ from IDCODE_OPCODE and must not be all-ones.
- IDCODE_VALUE, 32'h1000_0001, device ID; bit 0 must be 1.
- USER_WIDTH, 8, USER data register width; must be >= 1.

Ports:
- CLK  input  1  TCK; rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- state  input  4  current TAP state: 15 TLR, 12 RTI, 7 SelDR, 6 CapDR, 2 ShDR, 1 Ex1DR, 3 PauseDR, 0 Ex2DR, 5 UpdDR, 4 SelIR, 14 CapIR, 10 ShIR, 9 Ex1IR, 11 PauseIR, 8 Ex2IR, 13 UpdIR.
- tdi  input  1  serial test data in.
- tdo  output  1  serial test data out (combinational).
- tdo_en  output  1  high while shifting.
- ir  output  IR_WIDTH  active instruction.
- user_capture  input  USER_WIDTH  parallel value loaded in Capture-DR when USER is selected.
- user_update  output  USER_WIDTH  parallel value latched in Update-DR when USER is selected.
- user_strobe  output  1  one-cycle pulse when user_update is written.

Behaviour:
- Interface: reset RESET, asynchronous, active-high; clock CLK.
- Reset values on RESET:
  - ir = IDCODE_OPCODE; ir_shift = 0.
  - idcode_shift = 0; user_shift = 0; bypass = 0.
  - user_update = 0; user_strobe = 0.
- DR selection is decoded from ir:
  - ir == IDCODE_OPCODE -> IDCODE (32 bits).
  - ir == USER_OPCODE -> USER (USER_WIDTH bits).
  - any other value, including all-ones -> BYPASS (1 bit).
- Per rising CLK edge, by state:
  - 15 TLR: ir <= IDCODE_OPCODE. user_update is not touched; only RESET clears it.
  - 14 CapIR: ir_shift <= {0...0, 2'b01}.
  - 10 ShIR: ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]} (LSB out first).
  - 13 UpdIR: ir <= ir_shift.
  - 6 CapDR, by selected DR:
    - IDCODE: idcode_shift <= IDCODE_VALUE.
    - USER: user_shift <= user_capture (sampled at this edge).
    - BYPASS: bypass <= 0.
  - 2 ShDR: the selected register only shifts right, with tdi entering the MSB; BYPASS does bypass <= tdi. Unselected registers hold.
  - 5 UpdDR with USER selected: user_update <= user_shift; user_strobe <= 1.
  - All other states (RTI, Select, Exit1/2, Pause) hold every register; no shift occurs in Pause or Exit.
- user_strobe:
  - High exactly one cycle after the UpdDR edge.
  - Cleared on the next edge unless the state is UpdDR again.
  - No strobe when UpdDR occurs with IDCODE or BYPASS selected.
- tdo (combinational):
  - ShIR: ir_shift[0].
  - ShDR: bit 0 of the selected DR (bypass for BYPASS).
  - Otherwise 0.
- tdo_en = (state == 2) || (state == 10).
- Latency:
  - BYPASS delays tdi by exactly 1 shift cycle.
  - A full N-bit scan returns the captured value on the first N tdo samples, LSB first.
- Boundary conditions:
  - Shift cycles beyond the register length pass tdi data through after the captured bits.
  - An IR change takes effect only at UpdIR; a DR scan in flight uses the ir present at CapDR/ShDR edges.
  - RESET mid-scan immediately forces the reset values (async). The scan restarts from a Capture state.
  - Undefined state codes cannot occur (4-bit complete); there is no other state behaviour.

Test Plan:
1. Apply RESET, release, drive CapDR then 32× ShDR with tdi=0 -> ir=1; tdo_en=1 only during ShDR; tdo stream = 0x10000001 LSB first (1, then 27 zeros, then 1, then 3 zeros).
2. CapIR, then 4× ShIR with tdi=0,0,0,1, then UpdIR -> tdo during shift = 1,0,0,0; ir=4'h8 one edge after UpdIR.
3. ir=8, user_capture=0xA5; CapDR, 8× ShDR shifting 0x3C LSB first, UpdDR -> tdo = 0xA5 LSB first (1,0,1,0,0,1,0,1); user_update=0x3C; user_strobe high exactly one cycle.
4. ir=4'hF; CapDR, ShDR with tdi=1,0,1,1 -> tdo=0,1,0,1; UpdDR gives no user_strobe and user_update unchanged.
5. ir=8; shift 3 bits, then Ex1DR, 5× PauseDR, Ex2DR, then resume 5 bits -> registers hold during pause; final user_update matches the uninterrupted 8-bit scan.
6. Assert RESET after 4 ShIR bits, then separately enter TLR with ir=8 -> RESET: ir=1, ir_shift=0, user_update=0 asynchronously. TLR: ir=1 at the next edge, user_update unchanged.
